// File: rtl/iob_cache_tg_pkg.sv
// rtl/iob_cache_tg_pkg.sv - shared types, widths and pattern function for the cache traffic generator
// Contents: FSM state encoding (3-bit), error-counter width, per-word data pattern.
package iob_cache_tg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_RD_REQ  = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_DONE    = 3'd4
  } tg_state_t;

  localparam int ERR_W = 16;

  // Data for word idx; callers truncate the 64-bit sum to their data width.
  function automatic logic [63:0] tg_pattern(input logic [63:0] seed, input logic [63:0] idx);
    return seed + idx;
  endfunction

endpackage

// File: rtl/iob_cache_traffic_gen_if.sv
// rtl/iob_cache_traffic_gen_if.sv - IOB request/response bundle between traffic generator and cache
// master: valid/addr/wdata/wstrb out, ready/rvalid/rdata in. slave: the reverse.
interface iob_cache_traffic_gen_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                valid;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                ready;
  logic                rvalid;
  logic [DATA_W-1:0]   rdata;

  modport master (output valid, addr, wdata, wstrb, input ready, rvalid, rdata);
  modport slave  (input valid, addr, wdata, wstrb, output ready, rvalid, rdata);
endinterface

// File: rtl/iob_cache_tg_wdog.sv
// rtl/iob_cache_tg_wdog.sv - loadable watchdog up-counter with clear and terminal-count output
// Ports: clk_i, rst_n_i (sync active-low), en_i (clock enable), clr_i, load_i/load_val_i, tc_o.
module iob_cache_tg_wdog #(
  parameter int W = 10
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tc_o
);
  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [W-1:0] CNT_PRE = {{(W-1){1'b1}}, 1'b0};

  logic [W-1:0] cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt <= '0;
    end else if (en_i) begin
      if (clr_i)              cnt <= '0;
      else if (load_i)        cnt <= load_val_i;
      else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
    end
  end

  // Asserted on the edge where the count would reach its maximum, so the
  // owner reacts exactly 2^W-1 cycles after the last clear.
  assign tc_o = en_i & ~clr_i & ~load_i & (cnt == CNT_PRE);

endmodule

// File: rtl/iob_cache_traffic_gen.sv
// rtl/iob_cache_traffic_gen.sv - IOB initiator that writes a pattern block to the cache and reads it back
// Ports: clk_i, rst_n_i (sync active-low), cke_i, start_i, iob (IOB master),
//        busy_o, done_o, pass_o, timeout_o, err_cnt_o, first_err_addr_o.
module iob_cache_traffic_gen
  import iob_cache_tg_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                NWORDS_W  = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [31:0]       SEED      = 32'hA5A5_0000,
  parameter int                TIMEOUT_W = 10
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    cke_i,
  input  logic                    start_i,
  iob_cache_traffic_gen_if.master iob,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    pass_o,
  output logic                    timeout_o,
  output logic [ERR_W-1:0]        err_cnt_o,
  output logic [ADDR_W-1:0]       first_err_addr_o
);

  function automatic logic [ADDR_W-1:0] word_addr(input logic [NWORDS_W-1:0] n);
    return BASE_ADDR + ADDR_W'(n);
  endfunction

  function automatic logic [DATA_W-1:0] word_data(input logic [NWORDS_W-1:0] n);
    return DATA_W'(tg_pattern(64'(SEED), 64'(n)));
  endfunction

  tg_state_t           state;
  logic [NWORDS_W-1:0] idx;
  logic                last_word;
  logic                active;
  logic                hs;
  logic                rv;
  logic                mismatch;
  logic                wd_clr;
  logic                wd_tc;

  assign last_word = &idx;
  assign active    = (state == ST_WRITE) || (state == ST_RD_REQ) || (state == ST_RD_WAIT);
  assign hs        = iob.valid & iob.ready;
  assign rv        = iob.rvalid & (state == ST_RD_WAIT);
  assign mismatch  = iob.rdata != word_data(idx);
  // Idle states hold the watchdog at zero, which also covers the start transition.
  assign wd_clr    = ~active | hs | rv;

  iob_cache_tg_wdog #(.W(TIMEOUT_W)) u_wdog (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .en_i       (cke_i),
    .clr_i      (wd_clr),
    .load_i     (1'b0),
    .load_val_i ('0),
    .tc_o       (wd_tc)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state            <= ST_IDLE;
      idx              <= '0;
      iob.valid        <= 1'b0;
      iob.addr         <= '0;
      iob.wdata        <= '0;
      iob.wstrb        <= '0;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      pass_o           <= 1'b0;
      timeout_o        <= 1'b0;
      err_cnt_o        <= '0;
      first_err_addr_o <= '0;
    end else if (cke_i) begin
      if (active && wd_tc) begin
        state     <= ST_DONE;
        iob.valid <= 1'b0;
        busy_o    <= 1'b0;
        done_o    <= 1'b1;
        pass_o    <= 1'b0;
        timeout_o <= 1'b1;
      end else begin
        case (state)
          ST_IDLE, ST_DONE: begin
            if (start_i) begin
              state            <= ST_WRITE;
              idx              <= '0;
              iob.valid        <= 1'b1;
              iob.addr         <= word_addr('0);
              iob.wdata        <= word_data('0);
              iob.wstrb        <= '1;
              busy_o           <= 1'b1;
              done_o           <= 1'b0;
              pass_o           <= 1'b0;
              timeout_o        <= 1'b0;
              err_cnt_o        <= '0;
              first_err_addr_o <= '0;
            end
          end
          ST_WRITE: begin
            if (hs) begin
              if (last_word) begin
                // valid stays high: the first read request follows immediately.
                state     <= ST_RD_REQ;
                idx       <= '0;
                iob.addr  <= word_addr('0);
                iob.wdata <= '0;
                iob.wstrb <= '0;
              end else begin
                idx       <= idx + 1'b1;
                iob.addr  <= word_addr(idx + 1'b1);
                iob.wdata <= word_data(idx + 1'b1);
              end
            end
          end
          ST_RD_REQ: begin
            if (hs) begin
              state     <= ST_RD_WAIT;
              iob.valid <= 1'b0;
            end
          end
          ST_RD_WAIT: begin
            if (rv) begin
              if (mismatch) begin
                if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + 1'b1;
                if (err_cnt_o == '0) first_err_addr_o <= iob.addr;
              end
              if (last_word) begin
                state  <= ST_DONE;
                busy_o <= 1'b0;
                done_o <= 1'b1;
                pass_o <= ~mismatch & (err_cnt_o == '0);
              end else begin
                state     <= ST_RD_REQ;
                idx       <= idx + 1'b1;
                iob.valid <= 1'b1;
                iob.addr  <= word_addr(idx + 1'b1);
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_iob_cache_traffic_gen.sv
// tb/tb_iob_cache_traffic_gen.sv - self-checking bench for iob_cache_traffic_gen with a small memory model
module tb_iob_cache_traffic_gen;
  import iob_cache_tg_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic cke;
  logic start;
  logic busy, done, pass, timeout;
  logic [15:0] err_cnt;
  logic [31:0] first_err;

  always #5 clk = ~clk;

  iob_cache_traffic_gen_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  iob_cache_traffic_gen #(
    .ADDR_W(32), .DATA_W(32), .NWORDS_W(3), .BASE_ADDR(32'd0),
    .SEED(32'h100), .TIMEOUT_W(4)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .cke_i(cke), .start_i(start),
    .iob(bus),
    .busy_o(busy), .done_o(done), .pass_o(pass), .timeout_o(timeout),
    .err_cnt_o(err_cnt), .first_err_addr_o(first_err)
  );

  // memory model
  logic        rand_mode = 1'b0;
  logic        stuck_mode = 1'b0;
  logic [7:0]  corrupt_mask = 8'h00;
  logic [31:0] mem [0:7];
  logic [31:0] rdata_q = '0;
  int          stall = 0;
  int          pend = 0;
  int          wr_cnt = 0;

  assign bus.ready  = stuck_mode ? (wr_cnt < 2) : (stall == 0);
  assign bus.rvalid = (pend == 1);
  assign bus.rdata  = rdata_q;

  always @(posedge clk) begin
    if (!rst_n) begin
      stall  <= 0;
      pend   <= 0;
      wr_cnt <= 0;
    end else if (cke) begin
      if (pend != 0) pend <= pend - 1;
      if (bus.valid && bus.ready) begin
        stall <= rand_mode ? int'($urandom_range(0, 5)) : 0;
        if (bus.wstrb != 4'h0) begin
          mem[bus.addr[2:0]] <= bus.wdata;
          wr_cnt <= wr_cnt + 1;
        end else begin
          pend    <= rand_mode ? int'($urandom_range(1, 8)) : 1;
          rdata_q <= corrupt_mask[bus.addr[2:0]] ? 32'h0000_DEAD : mem[bus.addr[2:0]];
        end
      end else if (bus.valid && stall != 0) begin
        stall <= stall - 1;
      end
    end
  end

  // request-stability monitor
  logic        prev_stalled = 1'b0;
  logic [31:0] prev_addr = '0, prev_wdata = '0;
  logic [3:0]  prev_wstrb = '0;
  int          stab_viol = 0;

  always @(posedge clk) begin
    if (rst_n && cke && prev_stalled &&
        (!bus.valid || bus.addr != prev_addr || bus.wdata != prev_wdata || bus.wstrb != prev_wstrb))
      stab_viol <= stab_viol + 1;
    prev_stalled <= rst_n && cke && bus.valid && !bus.ready;
    prev_addr    <= bus.addr;
    prev_wdata   <= bus.wdata;
    prev_wstrb   <= bus.wstrb;
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] outs();
    return {7'd0, bus.valid, bus.addr, bus.wdata, bus.wstrb, busy, done, pass, timeout, err_cnt, first_err};
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    cke   = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [127:0] snap;

  // Pulses start, then runs until done (bounded). Cycle 1 is the first cycle after the start sample.
  task automatic run(input int pulse_at, input int freeze_at, input int freeze_len,
                     output int cyc, output int bcyc);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc  = 1;
    bcyc = 0;
    while (cyc < 2000) begin
      if (busy) bcyc++;
      if (done) break;
      start = (cyc == pulse_at);
      if (cyc == freeze_at) begin
        snap = outs();
        cke  = 1'b0;
      end
      if (freeze_at > 0 && cyc == freeze_at + freeze_len) begin
        chk("frozen outputs", outs(), snap);
        cke = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
  endtask

  typedef struct {
    bit         rnd;
    bit         stuck;
    logic [7:0] mask;
    bit         exp_pass;
    int         exp_err;
    int         exp_first;
    bit         exp_to;
    int         exp_cyc;
    int         exp_busy;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int cyc, bcyc;
    rst_n = 1'b0;
    cke   = 1'b1;
    start = 1'b0;

    vecs[0] = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 0, 1'b0, 25, 24};
    vecs[1] = '{1'b1, 1'b0, 8'h00, 1'b1, 0, 0, 1'b0, -1, -1};
    vecs[2] = '{1'b0, 1'b0, 8'h20, 1'b0, 1, 5, 1'b0, 25, 24};
    vecs[3] = '{1'b0, 1'b0, 8'h82, 1'b0, 2, 1, 1'b0, 25, 24};
    vecs[4] = '{1'b1, 1'b0, 8'h01, 1'b0, 1, 0, 1'b0, -1, -1};
    vecs[5] = '{1'b0, 1'b1, 8'h00, 1'b0, 0, 0, 1'b1, 18, 17};

    apply_reset();
    chk("reset outputs", outs(), 128'd0);

    for (int r = 0; r < 6; r++) begin
      apply_reset();
      rand_mode    = vecs[r].rnd;
      stuck_mode   = vecs[r].stuck;
      corrupt_mask = vecs[r].mask;
      run(-1, -1, 0, cyc, bcyc);
      chk($sformatf("row%0d done", r), 128'(done), 128'(1));
      chk($sformatf("row%0d pass", r), 128'(pass), 128'(vecs[r].exp_pass));
      chk($sformatf("row%0d err_cnt", r), 128'(err_cnt), 128'(vecs[r].exp_err));
      chk($sformatf("row%0d first_err", r), 128'(first_err), 128'(vecs[r].exp_first));
      chk($sformatf("row%0d timeout", r), 128'(timeout), 128'(vecs[r].exp_to));
      chk($sformatf("row%0d valid", r), 128'(bus.valid), 128'(0));
      chk($sformatf("row%0d busy", r), 128'(busy), 128'(0));
      if (vecs[r].exp_cyc >= 0) begin
        chk($sformatf("row%0d done cycle", r), 128'(cyc), 128'(vecs[r].exp_cyc));
        chk($sformatf("row%0d busy cycles", r), 128'(bcyc), 128'(vecs[r].exp_busy));
      end
      if (vecs[r].rnd) chk($sformatf("row%0d stable", r), 128'(stab_viol), 128'(0));
    end

    // reset asserted while waiting for word 1 read data
    apply_reset();
    rand_mode = 1'b0; stuck_mode = 1'b0; corrupt_mask = 8'h00;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    chk("rdwait valid", 128'(bus.valid), 128'(0));
    chk("rdwait busy", 128'(busy), 128'(1));
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrun reset outputs", outs(), 128'd0);
    chk("midrun reset state", 128'(dut.state), 128'(ST_IDLE));
    rst_n = 1'b1;
    run(-1, -1, 0, cyc, bcyc);
    chk("after reset pass", 128'(pass), 128'(1));
    chk("after reset cycle", 128'(cyc), 128'(25));

    // start pulse mid-run plus a 10-cycle clock-enable gap
    apply_reset();
    run(5, 14, 10, cyc, bcyc);
    chk("freeze done cycle", 128'(cyc), 128'(35));
    chk("freeze busy cycles", 128'(bcyc), 128'(34));
    chk("freeze pass", 128'(pass), 128'(1));
    chk("freeze err_cnt", 128'(err_cnt), 128'(0));

    // restart directly from DONE clears previous result
    corrupt_mask = 8'h20;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart done cleared", 128'(done), 128'(0));
    chk("restart valid", 128'(bus.valid), 128'(1));
    chk("restart wdata", 128'(bus.wdata), 128'(32'h100));
    begin : wait_done
      int n = 0;
      while (!done && n < 2000) begin
        @(negedge clk);
        n++;
      end
    end
    chk("restart done", 128'(done), 128'(1));
    chk("restart err_cnt", 128'(err_cnt), 128'(1));
    chk("restart first_err", 128'(first_err), 128'(5));
    chk("restart pass", 128'(pass), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
